// File: rtl/tri_scheduler.sv
// tri_scheduler: per-frame triangle sequencer in front of the rasterizer.
// On each new_frame_in pulse it reads three vertex words per triangle from a
// vertex memory with RD_LAT cycles of read latency. It assembles them into
// {v2,v1,v0} and hands each triangle over with a valid/ready handshake.
//
// Ports:
//   clk_in          pixel clock
//   rst_in          synchronous reset, active low
//   new_frame_in    frame-start pulse
//   mem_addr_out    vertex read address (holds its last value between reads)
//   mem_rd_out      read strobe, one vertex per cycle while fetching
//   mem_data_in     vertex word {x,y,z}, valid RD_LAT cycles after the read
//   tri_out         assembled triangle {v2,v1,v0}
//   tri_valid_out   tri_out holds a complete triangle
//   tri_ready_in    rasterizer accepts the triangle
//   obj_done_out    one-cycle pulse after the last triangle is accepted
//   busy_out        high whenever the sequencer is not idle
//   frame_drop_out  one-cycle pulse when a frame start is ignored
//   tri_count_out   triangles accepted in the current frame
module tri_scheduler #(
   parameter int unsigned NUM_TRIS = 12,
   parameter int unsigned COORD_W  = 32,
   parameter int unsigned RD_LAT   = 2,
   parameter int unsigned ADDR_W   = $clog2(3 * NUM_TRIS)
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic                           new_frame_in,
   output logic [ADDR_W-1:0]              mem_addr_out,
   output logic                           mem_rd_out,
   input  logic [3*COORD_W-1:0]           mem_data_in,
   output logic [9*COORD_W-1:0]           tri_out,
   output logic                           tri_valid_out,
   input  logic                           tri_ready_in,
   output logic                           obj_done_out,
   output logic                           busy_out,
   output logic                           frame_drop_out,
   output logic [$clog2(NUM_TRIS+1)-1:0]  tri_count_out
);

   localparam int unsigned CNT_W = $clog2(NUM_TRIS + 1);
   localparam int unsigned VW    = 3 * COORD_W;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] FETCH   = 3'd1;
   localparam logic [2:0] WAIT    = 3'd2;
   localparam logic [2:0] PRESENT = 3'd3;
   localparam logic [2:0] DONE    = 3'd4;

   localparam logic [CNT_W-1:0] LAST_TRI = CNT_W'(NUM_TRIS - 1);

   logic [2:0]              state_q, state_d;
   logic [1:0]              slot_q;
   logic [ADDR_W-1:0]       addr_q;
   logic [CNT_W-1:0]        count_q;
   logic                    drop_q;
   logic [VW-1:0]           v0_q, v1_q, v2_q;
   // Read-valid pipeline: each in-flight read carries the vertex slot it fills.
   logic [RD_LAT-1:0]       vld_q;
   logic [RD_LAT-1:0][1:0]  tag_q;

   logic       start;
   logic       handshake;
   logic       ret_valid;
   logic [1:0] ret_slot;
   logic       in_frame;

   always_comb begin
      in_frame  = (state_q == FETCH) || (state_q == WAIT) || (state_q == PRESENT);
      // A frame start is only honoured when idle or in the final DONE cycle.
      start     = new_frame_in && ((state_q == IDLE) || (state_q == DONE));
      handshake = (state_q == PRESENT) && tri_ready_in;
      ret_valid = vld_q[RD_LAT-1];
      ret_slot  = tag_q[RD_LAT-1];
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (new_frame_in) state_d = FETCH;
         FETCH:   if (slot_q == 2'd2) state_d = WAIT;
         WAIT:    if (ret_valid && (ret_slot == 2'd2)) state_d = PRESENT;
         PRESENT: if (tri_ready_in) state_d = (count_q == LAST_TRI) ? DONE : FETCH;
         DONE:    state_d = new_frame_in ? FETCH : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q <= IDLE;
         slot_q  <= '0;
         addr_q  <= '0;
         count_q <= '0;
         drop_q  <= 1'b0;
         v0_q    <= '0;
         v1_q    <= '0;
         v2_q    <= '0;
         vld_q   <= '0;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         drop_q  <= new_frame_in && in_frame;

         if (start) begin
            addr_q  <= '0;
            count_q <= '0;
            slot_q  <= '0;
         end else if (state_q == FETCH) begin
            if (slot_q != 2'd2) begin
               slot_q <= slot_q + 2'd1;
               addr_q <= addr_q + ADDR_W'(1);
            end
         end else if (handshake) begin
            count_q <= count_q + CNT_W'(1);
            // addr_q sits on 3t+2, so one more step is the next triangle's v0.
            if (count_q != LAST_TRI) begin
               addr_q <= addr_q + ADDR_W'(1);
               slot_q <= '0;
            end
         end

         vld_q[0] <= mem_rd_out;
         tag_q[0] <= slot_q;
         for (int i = 1; i < int'(RD_LAT); i++) begin
            vld_q[i] <= vld_q[i-1];
            tag_q[i] <= tag_q[i-1];
         end

         if (ret_valid) begin
            case (ret_slot)
               2'd0:    v0_q <= mem_data_in;
               2'd1:    v1_q <= mem_data_in;
               default: v2_q <= mem_data_in;
            endcase
         end
      end
   end

   assign mem_addr_out   = addr_q;
   assign mem_rd_out     = (state_q == FETCH);
   assign tri_out        = {v2_q, v1_q, v0_q};
   assign tri_valid_out  = (state_q == PRESENT);
   assign obj_done_out   = (state_q == DONE);
   assign busy_out       = (state_q != IDLE);
   assign frame_drop_out = drop_q;
   assign tri_count_out  = count_q;

endmodule

// File: tb/tb_tri_scheduler.sv
// tb_tri_scheduler: bench for tri_scheduler.
// dut_a: NUM_TRIS=2, RD_LAT=2.  dut_b: NUM_TRIS=1, RD_LAT=1.
// Vertex memory k holds {k, k+100, k+200}. Inputs change 1ns after the rising
// edge and outputs are sampled on the falling edge.
module tb_tri_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // ---------------- DUT A ----------------
   logic         rst_a, nf_a, rd_a, valid_a, ready_a, done_a, busy_a, drop_a;
   logic [2:0]   addr_a;
   logic [95:0]  data_a;
   logic [287:0] tri_a;
   logic [1:0]   cnt_a;

   tri_scheduler #(.NUM_TRIS(2), .COORD_W(32), .RD_LAT(2)) dut_a (
      .clk_in(clk), .rst_in(rst_a), .new_frame_in(nf_a),
      .mem_addr_out(addr_a), .mem_rd_out(rd_a), .mem_data_in(data_a),
      .tri_out(tri_a), .tri_valid_out(valid_a), .tri_ready_in(ready_a),
      .obj_done_out(done_a), .busy_out(busy_a), .frame_drop_out(drop_a),
      .tri_count_out(cnt_a)
   );

   // ---------------- DUT B ----------------
   logic         rst_b, nf_b, rd_b, valid_b, ready_b, done_b, busy_b, drop_b;
   logic [1:0]   addr_b;
   logic [95:0]  data_b;
   logic [287:0] tri_b;
   logic [0:0]   cnt_b;

   tri_scheduler #(.NUM_TRIS(1), .COORD_W(32), .RD_LAT(1)) dut_b (
      .clk_in(clk), .rst_in(rst_b), .new_frame_in(nf_b),
      .mem_addr_out(addr_b), .mem_rd_out(rd_b), .mem_data_in(data_b),
      .tri_out(tri_b), .tri_valid_out(valid_b), .tri_ready_in(ready_b),
      .obj_done_out(done_b), .busy_out(busy_b), .frame_drop_out(drop_b),
      .tri_count_out(cnt_b)
   );

   function automatic logic [95:0] word(input int k);
      return {32'(k), 32'(k + 100), 32'(k + 200)};
   endfunction

   function automatic logic [287:0] tri_exp(input int t);
      return {word(3 * t + 2), word(3 * t + 1), word(3 * t)};
   endfunction

   // Memory models: latency 2 for A, latency 1 for B.
   logic [95:0] pipe_a [2];
   logic [95:0] pipe_b;
   always @(posedge clk) begin
      pipe_a[0] <= word(int'(addr_a));
      pipe_a[1] <= pipe_a[0];
      pipe_b    <= word(int'(addr_b));
   end
   assign data_a = pipe_a[1];
   assign data_b = pipe_b;

   function automatic logic [9:0] st_a();
      return {rd_a, addr_a, valid_a, done_a, busy_a, drop_a, cnt_a};
   endfunction

   function automatic logic [9:0] ex_a(input logic rd, input int addr, input logic v,
                                       input logic d, input logic b, input logic dr,
                                       input int c);
      return {rd, 3'(addr), v, d, b, dr, 2'(c)};
   endfunction

   function automatic logic [7:0] st_b();
      return {rd_b, addr_b, valid_b, done_b, busy_b, drop_b, cnt_b};
   endfunction

   task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: expected triangles queued when a frame is started.
   logic [287:0] sb_q[$];
   always @(negedge clk) begin
      if (rst_a && valid_a && ready_a) begin
         if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_unexpected: got triangle %0h, expected none", tri_a);
         end else begin
            chk("sb_tri", tri_a, sb_q.pop_front());
         end
      end
   end

   task automatic push_frame_a();
      sb_q.push_back(tri_exp(0));
      sb_q.push_back(tri_exp(1));
   endtask

   // Per-cycle expectations for one A frame with tri_ready_in held high.
   typedef struct {
      logic nf;
      logic rd;
      int   addr;
      logic valid;
      logic done;
      logic busy;
      int   cnt;
   } row_t;
   row_t tbl[15];

   task automatic run_table(input int drop_at);
      for (int i = 0; i < 15; i++) begin
         cyc();
         nf_a = tbl[i].nf || (i == drop_at);
         @(negedge clk);
         if (i > 0)
            chk($sformatf("table_row%0d", i), st_a(),
                ex_a(tbl[i].rd, tbl[i].addr, tbl[i].valid, tbl[i].done, tbl[i].busy,
                     (drop_at > 0) && (i == drop_at + 1), tbl[i].cnt));
      end
      cyc();
      nf_a = 1'b0;
      @(negedge clk);
   endtask

   task automatic start_a();
      cyc();
      nf_a = 1'b1;
      @(negedge clk);
      cyc();
      nf_a = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_valid_a(input string name);
      for (int k = 0; k < 30 && !valid_a; k++) begin
         cyc();
         @(negedge clk);
      end
      if (!valid_a) timeout(name);
   endtask

   task automatic wait_done_a(input string name);
      for (int k = 0; k < 40 && !done_a; k++) begin
         cyc();
         @(negedge clk);
      end
      if (!done_a) timeout(name);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         cyc();
         @(negedge clk);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] exb [8];

      //              nf    rd    addr valid done  busy  cnt
      tbl[0]  = '{1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0};
      tbl[1]  = '{1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1, 0};
      tbl[2]  = '{1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b1, 0};
      tbl[3]  = '{1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b1, 0};
      tbl[4]  = '{1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b1, 0};
      tbl[5]  = '{1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b1, 0};
      tbl[6]  = '{1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b1, 0};
      tbl[7]  = '{1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b1, 1};
      tbl[8]  = '{1'b0, 1'b1, 4, 1'b0, 1'b0, 1'b1, 1};
      tbl[9]  = '{1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b1, 1};
      tbl[10] = '{1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b1, 1};
      tbl[11] = '{1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b1, 1};
      tbl[12] = '{1'b0, 1'b0, 5, 1'b1, 1'b0, 1'b1, 1};
      tbl[13] = '{1'b0, 1'b0, 5, 1'b0, 1'b1, 1'b1, 2};
      tbl[14] = '{1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b0, 2};

      // rd, addr, valid, done, busy, drop, cnt for B, rows 0..7 after new_frame
      exb[0] = 8'b0_00_0_0_0_0_0;
      exb[1] = 8'b1_00_0_0_1_0_0;
      exb[2] = 8'b1_01_0_0_1_0_0;
      exb[3] = 8'b1_10_0_0_1_0_0;
      exb[4] = 8'b0_10_0_0_1_0_0;
      exb[5] = 8'b0_10_1_0_1_0_0;
      exb[6] = 8'b0_10_0_1_1_0_1;
      exb[7] = 8'b0_10_0_0_0_0_1;

      rst_a = 1'b0; nf_a = 1'b0; ready_a = 1'b1;
      rst_b = 1'b0; nf_b = 1'b0; ready_b = 1'b1;

      // Reset state
      idle(3);
      chk("reset_a_outputs", st_a(), '0);
      chk("reset_a_tri", tri_a, '0);
      chk("reset_b_outputs", st_b(), '0);
      cyc();
      rst_a = 1'b1;
      @(negedge clk);

      // Frame 1: full timing, ready tied high
      push_frame_a();
      run_table(-1);
      idle(3);
      chk("count_hold_idle", {busy_a, cnt_a}, {1'b0, 2'd2});

      // Frame 2: backpressure on the first triangle
      cyc();
      ready_a = 1'b0;
      @(negedge clk);
      push_frame_a();
      start_a();
      wait_valid_a("bp_valid");
      for (int j = 0; j < 10; j++) begin
         cyc();
         @(negedge clk);
         chk("bp_hold", {valid_a, rd_a, cnt_a}, {1'b1, 1'b0, 2'd0});
         chk("bp_tri", tri_a, tri_exp(0));
      end
      cyc();
      ready_a = 1'b1;
      @(negedge clk);
      wait_done_a("bp_done");
      chk("bp_done_count", cnt_a, 2'd2);
      idle(2);

      // Frame 3: ignored new_frame while in WAIT
      push_frame_a();
      run_table(4);
      idle(2);

      // Frames 4/5: new_frame coincident with DONE restarts immediately
      push_frame_a();
      for (int i = 0; i < 16; i++) begin
         cyc();
         nf_a = (i == 0) || (i == 13);
         if (i == 13) push_frame_a();
         @(negedge clk);
         if (i == 13) chk("dn_done", {done_a, drop_a}, 2'b10);
         if (i == 14) chk("dn_restart", st_a(), ex_a(1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0));
         if (i == 15) chk("dn_nodrop", st_a(), ex_a(1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b0, 0));
      end
      cyc();
      nf_a = 1'b0;
      @(negedge clk);
      wait_done_a("f5_done");
      chk("f5_done_count", cnt_a, 2'd2);
      idle(2);

      // Reset while triangle 1 is presented
      cyc();
      ready_a = 1'b0;
      @(negedge clk);
      push_frame_a();
      start_a();
      wait_valid_a("rs_v0");
      cyc();
      ready_a = 1'b1;
      @(negedge clk);
      cyc();
      ready_a = 1'b0;
      @(negedge clk);
      wait_valid_a("rs_v1");
      cyc();
      rst_a = 1'b0;
      ready_a = 1'b1;
      nf_a = 1'b1;
      @(negedge clk);
      cyc();
      rst_a = 1'b1;
      nf_a = 1'b0;
      @(negedge clk);
      chk("rs_zero", st_a(), '0);
      chk("rs_zero_tri", tri_a, '0);
      for (int j = 0; j < 8; j++) begin
         cyc();
         @(negedge clk);
         chk("rs_quiet", st_a(), '0);
         chk("rs_quiet_tri", tri_a, '0);
      end
      chk("rs_sb_left", sb_q.size(), 1);
      sb_q.delete();

      // Reset mid-fetch: returning read data must be discarded
      cyc();
      nf_a = 1'b1;
      @(negedge clk);
      cyc();
      nf_a = 1'b0;
      @(negedge clk);
      cyc();
      rst_a = 1'b0;
      @(negedge clk);
      cyc();
      rst_a = 1'b1;
      @(negedge clk);
      for (int j = 0; j < 6; j++) begin
         chk("rf_quiet", st_a(), '0);
         chk("rf_tri", tri_a, '0);
         cyc();
         @(negedge clk);
      end

      // Recovery after reset
      push_frame_a();
      run_table(-1);

      // DUT B: single triangle, read latency 1
      cyc();
      rst_b = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         cyc();
         nf_b = (i == 0);
         @(negedge clk);
         if (i > 0) chk($sformatf("b_row%0d", i), st_b(), exb[i]);
         if (i == 5) chk("b_tri", tri_b, tri_exp(0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
